// File: rtl/pwm_breath_multi_if.sv
// Control and LED-pin bundle for pwm_breath_multi; the controller drives the master side.
// Sideband level signals only, no flow control.
interface pwm_breath_multi_if #(
  parameter int CHANNELS  = 4,
  parameter int PWM_STEPS = 1000
);
  localparam int CNT_W = $clog2(PWM_STEPS + 1);

  logic                      sync_i;
  logic [2*CHANNELS-1:0]     mode_i;
  logic [CNT_W*CHANNELS-1:0] duty_i;
  logic [7:0]                speed_i;
  logic [CHANNELS-1:0]       led_o;
  logic                      cycle_done_o;

  modport master (
    output sync_i, mode_i, duty_i, speed_i,
    input  led_o, cycle_done_o
  );

  modport slave (
    input  sync_i, mode_i, duty_i, speed_i,
    output led_o, cycle_done_o
  );
endinterface

// File: rtl/pwm_breath_multi.sv
// Multi-channel PWM LED driver (off/static/breath/blink) with shadowed settings.
// led_o is registered, 1 clk after a counter/phase change; no backpressure.
module pwm_breath_multi #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int TICK_HZ       = 1_000_000,
  parameter int PWM_STEPS     = 1000,
  parameter int STAGGER       = 1,
  parameter int ACTIVE_LOW    = 0
) (
  input logic clk_i,
  input logic rst,
  pwm_breath_multi_if.slave bus
);
  localparam int DIV   = CLK_FREQUENCY / TICK_HZ;
  localparam int MAX   = PWM_STEPS - 1;
  localparam int CNT_W = $clog2(PWM_STEPS + 1);
  localparam int PH_W  = $clog2(2 * MAX);
  localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W     = (CNT_W > PH_W) ? CNT_W : PH_W;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]           prescaler;
  logic [CNT_W-1:0]          cnt_pwm;
  logic [7:0]                spd_cnt;
  logic [7:0]                speed_sh;
  logic [2*CHANNELS-1:0]     mode_sh;
  logic [CNT_W*CHANNELS-1:0] duty_sh;
  logic [PH_W-1:0]           ph  [CHANNELS];
  logic [PH_W-1:0]           lvl [CHANNELS];
  logic [CHANNELS-1:0]       raw;
  logic                      tick;
  logic                      wrap;
  logic                      step;

  function automatic logic [PH_W-1:0] init_ph(input int c);
    if (STAGGER != 0) return PH_W'((c * 2 * MAX) / CHANNELS);
    return '0;
  endfunction

  assign tick = (prescaler == PS_W'(DIV - 1));
  assign wrap = tick && (cnt_pwm == CNT_W'(MAX));
  assign step = wrap && (spd_cnt == speed_sh);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      prescaler        <= '0;
      cnt_pwm          <= '0;
      spd_cnt          <= '0;
      speed_sh         <= '0;
      mode_sh          <= '0;
      duty_sh          <= '0;
      bus.led_o        <= {CHANNELS{POL}};
      bus.cycle_done_o <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) ph[c] <= init_ph(c);
    end else begin
      bus.led_o        <= raw ^ {CHANNELS{POL}};
      bus.cycle_done_o <= !bus.sync_i && step && (ph[0] == PH_W'(2 * MAX - 1));
      if (bus.sync_i) begin
        // Restart timing only; shadowed settings survive a sync.
        prescaler <= '0;
        cnt_pwm   <= '0;
        spd_cnt   <= '0;
        for (int c = 0; c < CHANNELS; c++) ph[c] <= init_ph(c);
      end else begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
        if (tick) cnt_pwm <= (cnt_pwm == CNT_W'(MAX)) ? '0 : cnt_pwm + CNT_W'(1);
        if (wrap) begin
          mode_sh  <= bus.mode_i;
          duty_sh  <= bus.duty_i;
          speed_sh <= bus.speed_i;
          spd_cnt  <= step ? 8'd0 : spd_cnt + 8'd1;
        end
        if (step) begin
          for (int c = 0; c < CHANNELS; c++)
            ph[c] <= (ph[c] == PH_W'(2 * MAX - 1)) ? '0 : ph[c] + PH_W'(1);
        end
      end
    end
  end

  // Triangle level from the phase: rises 0..MAX then falls back without repeating the peak.
  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lvl[c] = (ph[c] <= PH_W'(MAX)) ? ph[c] : PH_W'(2 * MAX) - ph[c];
      case (mode_sh[2*c +: 2])
        2'b01:   raw[c] = W'(cnt_pwm) < W'(duty_sh[CNT_W*c +: CNT_W]);
        2'b10:   raw[c] = W'(cnt_pwm) < W'(lvl[c]);
        2'b11:   raw[c] = ph[c] < PH_W'(MAX);
        default: raw[c] = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi: DIV=4, MAX=7, 32-clk carrier, plus an ACTIVE_LOW twin.
module tb_pwm_breath_multi;
  localparam int CH    = 4;
  localparam int STEPS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_breath_multi_if #(.CHANNELS(CH), .PWM_STEPS(STEPS)) bus ();
  pwm_breath_multi_if #(.CHANNELS(CH), .PWM_STEPS(STEPS)) bus_al ();

  assign bus_al.sync_i  = bus.sync_i;
  assign bus_al.mode_i  = bus.mode_i;
  assign bus_al.duty_i  = bus.duty_i;
  assign bus_al.speed_i = bus.speed_i;

  pwm_breath_multi #(.CHANNELS(CH), .CLK_FREQUENCY(4_000_000), .TICK_HZ(1_000_000),
                     .PWM_STEPS(STEPS), .STAGGER(1), .ACTIVE_LOW(0))
    dut (.clk_i(clk), .rst(rst), .bus(bus));

  pwm_breath_multi #(.CHANNELS(CH), .CLK_FREQUENCY(4_000_000), .TICK_HZ(1_000_000),
                     .PWM_STEPS(STEPS), .STAGGER(1), .ACTIVE_LOW(1))
    dut_al (.clk_i(clk), .rst(rst), .bus(bus_al));

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int hi_cnt[CH];
  int lo_al[CH];

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_window(input int n);
    for (int c = 0; c < CH; c++) begin
      hi_cnt[c] = 0;
      lo_al[c]  = 0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        hi_cnt[c] += int'(bus.led_o[c]);
        lo_al[c]  += int'(!bus_al.led_o[c]);
      end
    end
  endtask

  task automatic set_ch(input int c, input logic [1:0] m, input logic [3:0] d);
    bus.mode_i[2*c +: 2] = m;
    bus.duty_i[4*c +: 4] = d;
  endtask

  // Let one carrier wrap latch the inputs, then restart timing; returns at cycle 0.
  task automatic apply_and_sync();
    tick_n(33);
    bus.sync_i = 1'b1;
    tick_n(1);
    bus.sync_i = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    bus.sync_i  = 1'b0;
    bus.mode_i  = 8'hAA;
    bus.duty_i  = '0;
    bus.speed_i = 8'd0;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    checks++;
    if (bus.led_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_led: got %b want 0000", bus.led_o);
    end
    checks++;
    if (bus.cycle_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle_done: got %b want 0", bus.cycle_done_o);
    end
    checks++;
    if (bus_al.led_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_led_active_low: got %b want 1111", bus_al.led_o);
    end
    // Period 1 dark (shadows off), period 2 at levels 1,4,6,3; twin counts low samples.
    exp_q = {0, 0, 0, 0, 0, 0, 0, 0, 4, 16, 24, 12, 4, 16, 24, 12};
    for (int p = 0; p < 2; p++) begin
      count_window(32);
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (hi_cnt[c] !== e) begin
          errors++;
          $display("FAIL breath_p%0d ch%0d: high %0d want %0d", p + 1, c, hi_cnt[c], e);
        end
      end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (lo_al[c] !== e) begin
          errors++;
          $display("FAIL breath_al_p%0d ch%0d: low %0d want %0d", p + 1, c, lo_al[c], e);
        end
      end
    end
  endtask

  task automatic test_static();
    int duties[4] = '{5, 8, 0, 15};
    int highs[4]  = '{20, 32, 0, 32};
    int e;
    bus.mode_i = 8'h00;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 2'b01, 4'(duties[i]));
      exp_q.push_back(highs[i]);
      for (int c = 1; c < CH; c++) exp_q.push_back(0);
      apply_and_sync();
      count_window(32);
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (hi_cnt[c] !== e) begin
          errors++;
          $display("FAIL static_d%0d ch%0d: high %0d want %0d", duties[i], c, hi_cnt[c], e);
        end
      end
    end
  endtask

  task automatic test_shadow();
    int e;
    bus.mode_i = 8'h00;
    set_ch(0, 2'b01, 4'd2);
    apply_and_sync();
    exp_q = {8, 0, 1, 23};
    count_window(16);
    e = exp_q.pop_front();
    checks++;
    if (hi_cnt[0] !== e) begin
      errors++;
      $display("FAIL shadow_first_half: high %0d want %0d", hi_cnt[0], e);
    end
    set_ch(0, 2'b01, 4'd6);
    count_window(16);
    e = exp_q.pop_front();
    checks++;
    if (hi_cnt[0] !== e) begin
      errors++;
      $display("FAIL shadow_second_half: high %0d want %0d", hi_cnt[0], e);
    end
    count_window(1);
    e = exp_q.pop_front();
    checks++;
    if (hi_cnt[0] !== e) begin
      errors++;
      $display("FAIL shadow_boundary: high %0d want %0d", hi_cnt[0], e);
    end
    count_window(31);
    e = exp_q.pop_front();
    checks++;
    if (hi_cnt[0] !== e) begin
      errors++;
      $display("FAIL shadow_next_period: high %0d want %0d", hi_cnt[0], e);
    end
  endtask

  task automatic run_cycle_done(input logic [7:0] spd, input int span, input int period);
    int pulses[$];
    int e;
    int got;
    int n;
    bus.mode_i  = 8'hAA;
    bus.speed_i = spd;
    apply_and_sync();
    n = span / period;
    exp_q.push_back(n);
    for (int i = 1; i <= n; i++) exp_q.push_back(i * period);
    for (int t = 1; t <= span + 2; t++) begin
      tick_n(1);
      if (bus.cycle_done_o === 1'b1) pulses.push_back(t);
    end
    e = exp_q.pop_front();
    checks++;
    if (pulses.size() !== e) begin
      errors++;
      $display("FAIL cycle_done_count_s%0d: got %0d want %0d", spd, pulses.size(), e);
    end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      got = (i < pulses.size()) ? pulses[i] : -1;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_done_at_s%0d_%0d: got %0d want %0d", spd, i, got, e);
      end
    end
  endtask

  task automatic test_cycle_done();
    run_cycle_done(8'd0, 900, 448);
    run_cycle_done(8'd3, 1800, 1792);
  endtask

  task automatic test_blink();
    int e;
    bus.mode_i  = 8'h00;
    bus.speed_i = 8'd0;
    set_ch(0, 2'b11, 4'd0);
    apply_and_sync();
    exp_q = {224, 0};
    for (int h = 0; h < 2; h++) begin
      count_window(224);
      e = exp_q.pop_front();
      checks++;
      if (hi_cnt[0] !== e) begin
        errors++;
        $display("FAIL blink_half%0d: high %0d want %0d", h, hi_cnt[0], e);
      end
    end
  endtask

  task automatic test_sync_reset();
    int e;
    bus.mode_i  = 8'hAA;
    bus.speed_i = 8'd0;
    apply_and_sync();
    tick_n(100);
    bus.sync_i = 1'b1;
    tick_n(1);
    bus.sync_i = 1'b0;
    exp_q = {0, 12, 28, 16, 4, 16, 24, 12};
    for (int p = 0; p < 2; p++) begin
      count_window(32);
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (hi_cnt[c] !== e) begin
          errors++;
          $display("FAIL sync_p%0d ch%0d: high %0d want %0d", p + 1, c, hi_cnt[c], e);
        end
      end
    end
    bus.sync_i = 1'b1;
    tick_n(1);
    bus.sync_i = 1'b0;
    tick_n(5);
    checks++;
    if (bus.led_o !== 4'b1110) begin
      errors++;
      $display("FAIL pre_reset_led: got %b want 1110", bus.led_o);
    end
    rst = 1'b1;
    bus.sync_i = 1'b1;
    tick_n(1);
    rst = 1'b0;
    bus.sync_i = 1'b0;
    checks++;
    if (bus.led_o !== 4'b0000 || bus_al.led_o !== 4'b1111) begin
      errors++;
      $display("FAIL rst_sync_led: got %b/%b want 0000/1111", bus.led_o, bus_al.led_o);
    end
    exp_q = {0, 0, 0, 0, 4, 16, 24, 12};
    for (int p = 0; p < 2; p++) begin
      count_window(32);
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (hi_cnt[c] !== e) begin
          errors++;
          $display("FAIL after_rst_p%0d ch%0d: high %0d want %0d", p + 1, c, hi_cnt[c], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_shadow();
    test_cycle_done();
    test_blink();
    test_sync_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
